n_bit_mac_acc: RTL and testbench

- Sequential accumulator directly downstream of n_bit_mul.
- Consumes a stream of 2*BIT_DEPTH-bit unsigned products through a valid/ready handshake and sums a programmed number of them.
- Presents the sum through a registered valid/ready output.
- Together with n_bit_mul it forms the MAC datapath used for dot-product style workloads.

---
 rtl/n_bit_mac_acc.sv | 100 ++++++++++
 tb/tb_n_bit_mac_acc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_mac_acc.sv
// Valid/ready accumulator that sums a programmed number of unsigned products from n_bit_mul.
// Optional build macro N_BIT_MAC_SAT_EN: saturate the sum to all ones on overflow instead of wrapping.
module n_bit_mac_acc #(
    parameter int unsigned BIT_DEPTH = 32,
    parameter int unsigned ACC_GUARD = 8,
    parameter int unsigned CNT_WIDTH = 8,
    localparam int unsigned PROD_W   = 2 * BIT_DEPTH,
    localparam int unsigned ACC_W    = PROD_W + ACC_GUARD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [PROD_W-1:0]    prod_in,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    output logic [ACC_W-1:0]     acc_out,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic                 busy,
    output logic                 overflow
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [ACC_W:0]       sum_wide;
    logic                 carry;
    logic [ACC_W-1:0]     acc_next;

    // One extra bit so the carry out of the top accumulator bit is observable.
    always_comb begin
        sum_wide = {1'b0, acc_out} + {{(ACC_GUARD + 1){1'b0}}, prod_in};
        carry    = sum_wide[ACC_W];
`ifdef N_BIT_MAC_SAT_EN
        // Once clamped, any further add either carries again or adds zero, so it stays clamped.
        acc_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
        acc_next = sum_wide[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            acc_out    <= '0;
            overflow   <= 1'b0;
            prod_ready <= 1'b0;
            acc_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_out  <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            count_q    <= len;
                            state_q    <= StAccum;
                            prod_ready <= 1'b1;
                        end else begin
                            state_q   <= StHold;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                StAccum: begin
                    // prod_ready is high throughout this state, so prod_valid alone marks a beat.
                    if (prod_valid) begin
                        acc_out  <= acc_next;
                        overflow <= overflow | carry;
                        count_q  <= count_q - CNT_WIDTH'(1);
                        if (count_q == CNT_WIDTH'(1)) begin
                            state_q    <= StHold;
                            prod_ready <= 1'b0;
                            acc_valid  <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (acc_ready) begin
                        state_q   <= StIdle;
                        acc_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    prod_ready <= 1'b0;
                    acc_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_bit_mac_acc.sv
// Directed self-checking bench for n_bit_mac_acc (BIT_DEPTH=32, ACC_GUARD=0).
module tb_n_bit_mac_acc;

    localparam int unsigned BIT_DEPTH = 32;
    localparam int unsigned ACC_GUARD = 0;
    localparam int unsigned CNT_WIDTH = 8;
    localparam int unsigned PROD_W    = 2 * BIT_DEPTH;
    localparam int unsigned ACC_W     = PROD_W + ACC_GUARD;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [CNT_WIDTH-1:0] len;
    logic [PROD_W-1:0]    prod_in;
    logic                 prod_valid;
    logic                 prod_ready;
    logic [ACC_W-1:0]     acc_out;
    logic                 acc_valid;
    logic                 acc_ready;
    logic                 busy;
    logic                 overflow;

    int tests;
    int fails;

    n_bit_mac_acc #(
        .BIT_DEPTH (BIT_DEPTH),
        .ACC_GUARD (ACC_GUARD),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b0;
        #12;
        tests++;
        if ({acc_out, acc_valid, prod_ready, busy, overflow} !== {{ACC_W{1'b0}}, 4'b0000}) begin
            fails++;
            $display("FAIL reset_state: acc_out=%h v=%b pr=%b busy=%b ovf=%b, required all zero",
                     acc_out, acc_valid, prod_ready, busy, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [PROD_W-1:0] vals [3];
        int ready_cycles;
        vals[0] = 64'd9; vals[1] = 64'd3; vals[2] = 64'd120;
        ready_cycles = 0;
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (prod_ready) ready_cycles++;
            prod_valid = 1'b1; prod_in = vals[i];
            tick();
        end
        prod_valid = 1'b0;
        if (prod_ready) ready_cycles++;
        tests++;
        if (ready_cycles != 3) begin
            fails++;
            $display("FAIL basic_ready_cycles: got %0d, required 3", ready_cycles);
        end
        tests++;
        if (acc_valid !== 1'b1 || acc_out !== 64'd132 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: v=%b acc=%0d ovf=%b, required v=1 acc=132 ovf=0",
                     acc_valid, acc_out, overflow);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        tests++;
        if (busy !== 1'b0 || acc_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle: busy=%b v=%b, required 0 0", busy, acc_valid);
        end
    endtask

    task automatic test_stall_hold();
        int bad_hold;
        bad_hold = 0;
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_in = 64'd9;
        tick();
        prod_valid = 1'b0; prod_in = 64'hDEAD;
        tick();
        tick();
        tests++;
        if (acc_out !== 64'd9 || prod_ready !== 1'b1 || acc_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_no_change: acc=%0d pr=%b v=%b, required acc=9 pr=1 v=0",
                     acc_out, prod_ready, acc_valid);
        end
        prod_valid = 1'b1; prod_in = 64'd3;
        tick();
        prod_in = 64'd120;
        tick();
        prod_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (acc_valid !== 1'b1 || acc_out !== 64'd132) bad_hold++;
            tick();
        end
        tests++;
        if (bad_hold != 0) begin
            fails++;
            $display("FAIL stall_hold_stable: %0d bad hold cycles, required 0 (acc=%0d v=%b)",
                     bad_hold, acc_out, acc_valid);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        tests++;
        if (busy !== 1'b0 || acc_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_idle: busy=%b v=%b, required 0 0", busy, acc_valid);
        end
    endtask

    task automatic test_len_zero();
        int ready_seen;
        ready_seen = 0;
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        if (prod_ready) ready_seen++;
        tests++;
        if (acc_valid !== 1'b1 || acc_out !== 64'd0) begin
            fails++;
            $display("FAIL len0_result: v=%b acc=%h, required v=1 acc=0", acc_valid, acc_out);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        if (prod_ready) ready_seen++;
        tests++;
        if (ready_seen != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL len0_no_ready: ready_seen=%0d busy=%b, required 0 0", ready_seen, busy);
        end
    endtask

    task automatic test_overflow();
        logic [ACC_W-1:0] exp_acc;
`ifdef N_BIT_MAC_SAT_EN
        exp_acc = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp_acc = 64'hFFFF_FFFC_0000_0002;
`endif
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_in = 64'hFFFF_FFFE_0000_0001;
        tick();
        tick();
        prod_valid = 1'b0;
        tests++;
        if (acc_valid !== 1'b1 || acc_out !== exp_acc) begin
            fails++;
            $display("FAIL ovf_sum: v=%b acc=%h, required v=1 acc=%h", acc_valid, acc_out, exp_acc);
        end
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flag: got %b, required 1", overflow);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_abort();
        int valid_seen;
        valid_seen = 0;
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_in = 64'd77;
        tick();
        tick();
        prod_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        tests++;
        if (busy !== 1'b0 || acc_out !== 64'd0 || prod_ready !== 1'b0 || acc_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: busy=%b acc=%h pr=%b v=%b, required all zero",
                     busy, acc_out, prod_ready, acc_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acc_valid) valid_seen++;
        end
        tests++;
        if (valid_seen != 0) begin
            fails++;
            $display("FAIL abort_no_valid: acc_valid seen %0d cycles, required 0", valid_seen);
        end
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_in = 64'h0000_FFFE_0000_0001;
        tick();
        prod_valid = 1'b0;
        tests++;
        if (acc_valid !== 1'b1 || acc_out !== 64'h0000_FFFE_0000_0001 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL abort_new_job: v=%b acc=%h ovf=%b, required v=1 acc=0000fffe00000001 ovf=0",
                     acc_valid, acc_out, overflow);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_in = 64'd5;
        tick();
        // start while busy with a different len must be ignored
        prod_valid = 1'b0; start = 1'b1; len = 8'd7;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_in = 64'd6;
        tick();
        prod_valid = 1'b0;
        tests++;
        if (acc_valid !== 1'b1 || acc_out !== 64'd11) begin
            fails++;
            $display("FAIL busy_start_ignored: v=%b acc=%0d, required v=1 acc=11", acc_valid, acc_out);
        end
        start = 1'b1; len = 8'd1; acc_ready = 1'b1;
        tick();
        start = 1'b0; acc_ready = 1'b0;
        tests++;
        if (busy !== 1'b0 || acc_valid !== 1'b0 || prod_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_start_idle: busy=%b v=%b pr=%b, required 0 0 0",
                     busy, acc_valid, prod_ready);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || prod_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_start_not_latched: busy=%b pr=%b, required 0 0", busy, prod_ready);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_stall_hold();
        test_len_zero();
        test_overflow();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
